// File: rtl/program_loader.sv
// Program-store write side: operator keyed byte entry into a DEPTH-entry RAM, registered fetch port.
// Optional LOADER_CHECKSUM_EN adds a running mod-256 checksum of accepted writes.
module program_loader #(
    parameter int          ADDR_W     = 4,
    parameter logic [7:0]  FILL_VALUE = 8'hFF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              mode_prog_i,
    input  logic [7:0]        wr_data_i,
    input  logic              wr_strobe_i,
    input  logic              addr_load_i,
    input  logic              clr_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              overflow_o,
`ifdef LOADER_CHECKSUM_EN
    output logic [7:0]        checksum_o,
`endif
    output logic              busy_o
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_PROG} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        rd_data_q;
    logic              full;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem [DEPTH];

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;
`endif

    assign full = (count_q == FULL_CNT);

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        mem_addr   = wr_ptr_q;
        mem_wdata  = wr_data_i;
`ifdef LOADER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        case (state_q)
            S_CLEAR: begin
                // One fill write per cycle; clr_idx wraps back to 0 ready for the next CLEAR.
                mem_we    = 1'b1;
                mem_addr  = clr_idx_q;
                mem_wdata = FILL_VALUE;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d  = mode_prog_i ? S_PROG : S_IDLE;
                    wr_ptr_d = '0;
                    count_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            S_IDLE: begin
                if (mode_prog_i) state_d = S_PROG;
            end
            S_PROG: begin
                if (clr_req_i) begin
                    state_d    = S_CLEAR;
                    overflow_d = 1'b0;
                end else begin
                    if (!mode_prog_i) state_d = S_IDLE;
                    if (addr_load_i) begin
                        wr_ptr_d = wr_data_i[ADDR_W-1:0];
                    end else if (wr_strobe_i) begin
                        if (full) begin
                            overflow_d = 1'b1;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            count_d  = count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            checksum_d = checksum_q + wr_data_i;
`endif
                        end
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_CLEAR;
            clr_idx_q  <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= FILL_VALUE;
`ifdef LOADER_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            // The processor sees no-ops whenever the store is being edited or filled.
            rd_data_q  <= (state_q == S_IDLE) ? mem[rd_addr_i] : FILL_VALUE;
`ifdef LOADER_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    // RAM has no reset; CLEAR initialises it after every reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign rd_data_o  = rd_data_q;
    assign wr_ptr_o   = wr_ptr_q;
    assign count_o    = count_q;
    assign full_o     = full;
    assign overflow_o = overflow_q;
    assign busy_o     = (state_q == S_CLEAR);
`ifdef LOADER_CHECKSUM_EN
    assign checksum_o = checksum_q;
`endif
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized editing,
// compared against a transaction-level model of the program store.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       mode_prog;
    logic [7:0] wr_data;
    logic       wr_strobe;
    logic       addr_load;
    logic       clr_req;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] wr_ptr;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       busy;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    program_loader dut (
        .clk_i(clk), .reset_i(reset), .mode_prog_i(mode_prog), .wr_data_i(wr_data),
        .wr_strobe_i(wr_strobe), .addr_load_i(addr_load), .clr_req_i(clr_req),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .wr_ptr_o(wr_ptr), .count_o(count),
        .full_o(full), .overflow_o(overflow),
`ifdef LOADER_CHECKSUM_EN
        .checksum_o(checksum),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model of the store
    logic [7:0] m_mem [16];
    int         m_ptr, m_cnt;
    bit         m_ovf;
    logic [7:0] m_ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_mem[i] = 8'hFF;
        m_ptr = 0; m_cnt = 0; m_ovf = 0; m_ck = 8'h00;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".wr_ptr"}, 32'(wr_ptr), 32'(m_ptr));
        chk({tag, ".count"}, 32'(count), 32'(m_cnt));
        chk({tag, ".full"}, 32'(full), 32'(m_cnt == 16));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".busy"}, 32'(busy), 32'(0));
`ifdef LOADER_CHECKSUM_EN
        chk({tag, ".checksum"}, 32'(checksum), 32'(m_ck));
`endif
    endtask

    // One PROG cycle; leave=1 drops mode_prog in the same cycle
    task automatic step(input bit s, input bit l, input logic [7:0] d, input bit leave);
        wr_strobe = s; addr_load = l; wr_data = d;
        if (leave) mode_prog = 1'b0;
        tick();
        wr_strobe = 1'b0; addr_load = 1'b0;
        if (l) m_ptr = d % 16;
        else if (s) begin
            if (m_cnt < 16) begin
                m_mem[m_ptr] = d;
                m_ptr = (m_ptr + 1) % 16;
                m_cnt++;
                m_ck = m_ck + d;
            end else m_ovf = 1;
        end
        check_state("step");
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            n++;
            wr_strobe = 1'(($urandom & 1));
            addr_load = 1'(($urandom & 1));
            wr_data   = 8'($urandom);
            tick();
        end
        wr_strobe = 1'b0; addr_load = 1'b0;
        chk({tag, ".busy_len"}, 32'(n), 32'(16));
    endtask

    task automatic do_clear();
        clr_req = 1'b1; wr_strobe = 1'b1; addr_load = 1'b1; wr_data = 8'h07;
        tick();
        clr_req = 1'b0;
        wait_busy("clear");
        model_clear();
        check_state("after_clear");
    endtask

    // Sweep every address in run mode, then return to PROG
    task automatic read_all(input string tag);
        mode_prog = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            rd_addr = 4'(a);
            tick();
            chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_mem[a]));
        end
        mode_prog = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; mode_prog = 1'b0; wr_data = '0; wr_strobe = 1'b0;
        addr_load = 1'b0; clr_req = 1'b0; rd_addr = '0;
        model_clear();
        tick(); tick();
        chk("rst.busy", 32'(busy), 32'(1));
        chk("rst.wr_ptr", 32'(wr_ptr), 32'(0));
        chk("rst.count", 32'(count), 32'(0));
        chk("rst.full", 32'(full), 32'(0));
        chk("rst.overflow", 32'(overflow), 32'(0));
        chk("rst.rd_data", 32'(rd_data), 32'(8'hFF));
        reset = 1'b0;

        // Power-up fill into run mode, all locations read back as no-ops
        wait_busy("powerup");
        check_state("idle");
        read_all("fill");

        // Basic entry
        step(1, 0, 8'h90, 0); step(1, 0, 8'hA4, 0);
        step(1, 0, 8'h00, 0); step(1, 0, 8'hB0, 0);
        chk("t2.wr_ptr", 32'(wr_ptr), 32'(4));
        mode_prog = 1'b0; rd_addr = 4'd1;
        tick(); tick();
        chk("t2.rd1", 32'(rd_data), 32'(8'hA4));
        mode_prog = 1'b1; tick();

        // Address load then wrap past the top
        step(0, 1, 8'h0E, 0);
        step(1, 0, 8'h55, 0); step(1, 0, 8'h66, 0); step(1, 0, 8'h77, 0);
        chk("t3.wr_ptr", 32'(wr_ptr), 32'(1));
        read_all("wrap");

        // Fill to saturation, then overflow, then load-beats-strobe
        for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom), 0);
        chk("t4.full", 32'(full), 32'(1));
        step(1, 0, 8'h12, 0);
        chk("t4.overflow", 32'(overflow), 32'(1));
        step(1, 1, 8'h03, 0);
        read_all("sat");

        // CLEAR from PROG, then reset in the middle of a CLEAR
        do_clear();
        read_all("clr");
        clr_req = 1'b1; tick(); clr_req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1; #2;
        chk("midrst.busy", 32'(busy), 32'(1));
        reset = 1'b0;
        wait_busy("midrst");
        model_clear();
        check_state("midrst");

        // Fetch returns no-ops while editing
        step(1, 0, 8'h90, 0);
        rd_addr = 4'd0;
        tick();
        chk("t6.prog_rd", 32'(rd_data), 32'(8'hFF));
        mode_prog = 1'b0; tick();
        chk("t6.exit_rd", 32'(rd_data), 32'(8'hFF));
        tick();
        chk("t6.idle_rd", 32'(rd_data), 32'(8'h90));

        // Strobes in IDLE are ignored; a strobe in the last PROG cycle lands
        wr_strobe = 1'b1; addr_load = 1'b0; wr_data = 8'h5A; tick();
        addr_load = 1'b1; tick();
        wr_strobe = 1'b0; addr_load = 1'b0;
        check_state("idle_ign");
        mode_prog = 1'b1; tick();
        step(1, 0, 8'h3C, 1);
        read_all("leave");

        // Randomized editing
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 99);
            if (r < 2) do_clear();
            else if (r < 4) read_all("rand");
            else step(r < 75, (r >= 85 && r < 95) || (r >= 95 && r < 98),
                      8'($urandom), 0);
        end
        read_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
